// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE 16-bit core control path.
// Contents:
//   state_e      : sequencer states (idle, five phases, halt)
//   OP_*         : major opcode field ins[15:14]
//   EXT_*        : extended ALU op field ins[7:4]
//   BR_* / COND_*: branch sub-op ins[13:11] and condition ins[10:8]
//   phase_state  : maps a phase number 1..5 onto its state
package simple_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_P5   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [3:0] EXT_OUT = 4'b1101;
    localparam logic [3:0] EXT_HLT = 4'b1111;
    localparam logic [3:0] EXT_UNUSED_LO = 4'b0111;
    localparam logic [3:0] EXT_UNUSED_HI = 4'b1011;

    localparam logic [2:0] BR_LI     = 3'b000;
    localparam logic [2:0] BR_ALWAYS = 3'b100;
    localparam logic [2:0] BR_COND   = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    function automatic state_e phase_state(input int unsigned p);
        case (p)
            2:       return S_P2;
            3:       return S_P3;
            4:       return S_P4;
            5:       return S_P5;
            default: return S_P1;
        endcase
    endfunction

endpackage

// File: rtl/simple_branch_cond.sv
// Branch condition evaluation (purely combinational).
// Ports:
//   szcv_i        : architectural flags {S,Z,C,V}
//   instruction_i : current instruction word
//   taken_o       : 1 when the instruction is a branch whose condition holds
module simple_branch_cond
    import simple_pkg::*;
(
    input  logic [3:0]  szcv_i,
    input  logic [15:0] instruction_i,
    output logic        taken_o
);

    logic flag_s, flag_z, flag_v;
    logic lt;

    assign flag_s = szcv_i[3];
    assign flag_z = szcv_i[2];
    assign flag_v = szcv_i[0];
    assign lt     = flag_s ^ flag_v;

    // Carry and the low instruction bits never influence a branch decision.
    logic unused_bits;
    assign unused_bits = ^{szcv_i[1], instruction_i[7:0]};

    always_comb begin
        taken_o = 1'b0;
        if (instruction_i[15:14] == OP_BR) begin
            case (instruction_i[13:11])
                BR_ALWAYS: taken_o = 1'b1;
                BR_COND: begin
                    case (instruction_i[10:8])
                        COND_BE:  taken_o = flag_z;
                        COND_BLT: taken_o = lt;
                        COND_BLE: taken_o = flag_z | lt;
                        COND_BNE: taken_o = ~flag_z;
                        default:  taken_o = 1'b0;
                    endcase
                end
                default: taken_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/simple_phase_sequencer.sv
// Five-phase control sequencer for the SIMPLE 16-bit core.
// Steps P1..P5 per instruction, issues datapath write strobes, owns the SZCV flag register and
// evaluates branch conditions.
// Optional feature: define SIMPLE_SINGLE_STEP_EN to add the 'step' input (single-instruction step).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   run           : 1 = execute; 0 = stop at the next P5->P1 boundary
//   step          : (SIMPLE_SINGLE_STEP_EN only) rising edge in IDLE runs one instruction
//   instruction   : IR contents
//   alu_szcv      : ALU flags {S,Z,C,V} produced in P3
//   phase         : one-hot P1..P5 (bit0 = P1), 0 in IDLE/HALT
//   ir_we, pc_inc, pc_load, szcv_we, mem_we, reg_we : one-cycle datapath strobes
//   szcv          : architectural flags
//   halted        : HLT has executed
module simple_phase_sequencer
    import simple_pkg::*;
#(
    parameter int unsigned RESUME_PHASE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
`ifdef SIMPLE_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] instruction,
    input  logic [3:0]  alu_szcv,
    output logic [4:0]  phase,
    output logic        ir_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        szcv_we,
    output logic        mem_we,
    output logic        reg_we,
    output logic [3:0]  szcv,
    output logic        halted
);

    state_e     state_q, state_d;
    logic [3:0] szcv_q;
    logic       halted_q, halted_d;
    logic       taken;

    localparam state_e ResumeState = phase_state(RESUME_PHASE);

    // Instruction decode
    logic [1:0] op;
    logic [3:0] ext;
    logic       is_alu, is_out, is_hlt, ext_unused, is_li;

    assign op         = instruction[15:14];
    assign ext        = instruction[7:4];
    assign is_alu     = (op == OP_ALU);
    assign is_out     = is_alu && (ext == EXT_OUT);
    assign is_hlt     = is_alu && (ext == EXT_HLT);
    assign ext_unused = (ext >= EXT_UNUSED_LO) && (ext <= EXT_UNUSED_HI);
    assign is_li      = (op == OP_BR) && (instruction[13:11] == BR_LI);

    logic unused_bits;
    assign unused_bits = ^instruction[3:0];

    simple_branch_cond u_branch_cond (
        .szcv_i        (szcv_q),
        .instruction_i (instruction),
        .taken_o       (taken)
    );

`ifdef SIMPLE_SINGLE_STEP_EN
    logic step_q;
    logic single_q, single_d;
    logic step_rise;

    assign step_rise = step & ~step_q;
`endif

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            szcv_q   <= 4'b0000;
            halted_q <= 1'b0;
`ifdef SIMPLE_SINGLE_STEP_EN
            step_q   <= 1'b0;
            single_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            if (szcv_we) begin
                szcv_q <= alu_szcv;
            end
`ifdef SIMPLE_SINGLE_STEP_EN
            step_q   <= step;
            single_q <= single_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
`ifdef SIMPLE_SINGLE_STEP_EN
        single_d = single_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef SIMPLE_SINGLE_STEP_EN
                if (step_rise) begin
                    state_d  = ResumeState;
                    single_d = 1'b1;
                end else if (run) begin
                    state_d = ResumeState;
                end
`else
                if (run) begin
                    state_d = ResumeState;
                end
`endif
            end
            S_P1: state_d = S_P2;
            S_P2: begin
                if (is_hlt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_P3;
                end
            end
            S_P3: state_d = S_P4;
            S_P4: state_d = S_P5;
            S_P5: begin
`ifdef SIMPLE_SINGLE_STEP_EN
                if (run && !single_q) begin
                    state_d = S_P1;
                end else begin
                    state_d  = S_IDLE;
                    single_d = 1'b0;
                end
`else
                state_d = run ? S_P1 : S_IDLE;
`endif
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase indicator and strobes, decoded from state and instruction
    always_comb begin
        phase   = 5'b00000;
        ir_we   = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        szcv_we = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        unique case (state_q)
            S_P1: begin
                phase[0] = 1'b1;
                ir_we    = 1'b1;
                pc_inc   = 1'b1;
            end
            S_P2: phase[1] = 1'b1;
            S_P3: begin
                phase[2] = 1'b1;
                szcv_we  = is_alu && !is_out && !is_hlt;
            end
            S_P4: begin
                phase[3] = 1'b1;
                mem_we   = (op == OP_ST);
            end
            S_P5: begin
                phase[4] = 1'b1;
                reg_we   = (is_alu && !is_out && !is_hlt && !ext_unused) || (op == OP_LD) || is_li;
                pc_load  = taken;
            end
            S_IDLE, S_HALT: ;
            default: ;
        endcase
    end

    assign szcv   = szcv_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_simple_phase_sequencer.sv
module tb_simple_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
`ifdef SIMPLE_SINGLE_STEP_EN
    logic        step;
`endif
    logic [15:0] instruction;
    logic [3:0]  alu_szcv;
    logic [4:0]  phase;
    logic        ir_we, pc_inc, pc_load, szcv_we, mem_we, reg_we;
    logic [3:0]  szcv;
    logic        halted;

    // {ir_we, pc_inc, szcv_we, mem_we, reg_we, pc_load}
    logic [5:0]  strobes;
    assign strobes = {ir_we, pc_inc, szcv_we, mem_we, reg_we, pc_load};

    int checks = 0;
    int errors = 0;

    logic [4:0] ph  [5];
    logic [5:0] stb [5];
    logic [3:0] flg [5];

    simple_phase_sequencer #(.RESUME_PHASE(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
`ifdef SIMPLE_SINGLE_STEP_EN
        .step        (step),
`endif
        .instruction (instruction),
        .alu_szcv    (alu_szcv),
        .phase       (phase),
        .ir_we       (ir_we),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .szcv_we     (szcv_we),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .szcv        (szcv),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction P1..P5 (next edge must enter P1), recording per-phase observations.
    task automatic instr(input logic [15:0] ins, input logic [3:0] alu);
        instruction = ins;
        alu_szcv    = alu;
        for (int i = 0; i < 5; i++) begin
            tick();
            ph[i]  = phase;
            stb[i] = strobes;
            flg[i] = szcv;
        end
    endtask

    task automatic chk_phases(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_ph%0d", tag, i + 1), {27'd0, ph[i]}, 32'd1 << i);
        end
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        instruction = 16'h0000;
        alu_szcv    = 4'b0000;
`ifdef SIMPLE_SINGLE_STEP_EN
        step        = 1'b0;
`endif
        tick();
        tick();
        chk("rst_phase", {27'd0, phase}, 32'd0);
        chk("rst_szcv", {28'd0, szcv}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_strobes", {26'd0, strobes}, 32'd0);

        reset = 1'b0;
        tick();
        chk("idle_run0", {27'd0, phase}, 32'd0);

        // Reset asserted mid-P3 aborts the instruction
        run         = 1'b1;
        instruction = 16'hC000;
        alu_szcv    = 4'b0100;
        tick();
        chk("t1_p1", {27'd0, phase}, 32'h01);
        tick();
        tick();
        chk("t1_p3", {27'd0, phase}, 32'h04);
        chk("t1_p3_szcv_we", {31'd0, szcv_we}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t1_rst_phase", {27'd0, phase}, 32'd0);
        chk("t1_rst_szcv", {28'd0, szcv}, 32'd0);
        chk("t1_rst_strobes", {26'd0, strobes}, 32'd0);
        reset    = 1'b0;
        alu_szcv = 4'b0000;
        tick();
        chk("t1_resume_p1", {27'd0, phase}, 32'h01);
        for (int i = 0; i < 4; i++) tick();
        chk("t1_end_p5", {27'd0, phase}, 32'h10);

        // ADD
        instr(16'hC000, 4'b0100);
        chk_phases("add");
        chk("add_p1_stb", {26'd0, stb[0]}, 32'b110000);
        chk("add_p2_stb", {26'd0, stb[1]}, 32'b000000);
        chk("add_p3_stb", {26'd0, stb[2]}, 32'b001000);
        chk("add_p4_stb", {26'd0, stb[3]}, 32'b000000);
        chk("add_p5_stb", {26'd0, stb[4]}, 32'b000010);
        chk("add_szcv_in_p3", {28'd0, flg[2]}, 32'h0);
        chk("add_szcv_after_p3", {28'd0, flg[3]}, 32'h4);

        // ST leaves flags alone
        instr(16'h4000, 4'b1111);
        chk_phases("st");
        chk("st_p3_stb", {26'd0, stb[2]}, 32'b000000);
        chk("st_p4_stb", {26'd0, stb[3]}, 32'b000100);
        chk("st_p5_stb", {26'd0, stb[4]}, 32'b000000);
        chk("st_szcv", {28'd0, flg[4]}, 32'h4);

        // Branches
        instr(16'hB800, 4'b0000);
        chk("be_z1_p5", {26'd0, stb[4]}, 32'b000001);
        chk("be_p3_no_flag", {26'd0, stb[2]}, 32'b000000);
        chk("be_szcv", {28'd0, flg[4]}, 32'h4);
        instr(16'hC000, 4'b0000);
        chk("add0_szcv", {28'd0, flg[4]}, 32'h0);
        instr(16'hB800, 4'b0000);
        chk("be_z0_p5", {26'd0, stb[4]}, 32'b000000);
        instr(16'hC000, 4'b1000);
        chk("add_s_szcv", {28'd0, flg[4]}, 32'h8);
        instr(16'hB900, 4'b0000);
        chk("blt_taken", {26'd0, stb[4]}, 32'b000001);
        instr(16'hBA00, 4'b0000);
        chk("ble_taken", {26'd0, stb[4]}, 32'b000001);
        instr(16'hBB00, 4'b0000);
        chk("bne_taken", {26'd0, stb[4]}, 32'b000001);
        instr(16'hBC00, 4'b0000);
        chk("b1xx_never", {26'd0, stb[4]}, 32'b000000);
        instr(16'hA000, 4'b0000);
        chk("b_always", {26'd0, stb[4]}, 32'b000001);
        instr(16'h8000, 4'b0000);
        chk("li_reg_we", {26'd0, stb[4]}, 32'b000010);
        instr(16'h0000, 4'b0000);
        chk("ld_reg_we", {26'd0, stb[4]}, 32'b000010);
        instr(16'hC0D0, 4'b0101);
        chk("out_no_flag", {26'd0, stb[2]}, 32'b000000);
        chk("out_no_reg", {26'd0, stb[4]}, 32'b000000);
        chk("out_szcv", {28'd0, flg[4]}, 32'h8);

        // run falling mid-instruction: completes through P5, then IDLE
        instruction = 16'hC000;
        alu_szcv    = 4'b0000;
        tick();
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        chk("runfall_p5", {27'd0, phase}, 32'h10);
        chk("runfall_p5_reg_we", {31'd0, reg_we}, 32'd1);
        tick();
        chk("runfall_idle", {27'd0, phase}, 32'd0);
        tick();
        chk("runfall_idle2", {27'd0, phase}, 32'd0);

        // HLT
        run         = 1'b1;
        instruction = 16'hC0F0;
        tick();
        tick();
        chk("hlt_p2", {27'd0, phase}, 32'h02);
        chk("hlt_p2_halted", {31'd0, halted}, 32'd0);
        tick();
        chk("hlt_phase", {27'd0, phase}, 32'd0);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_strobes", {26'd0, strobes}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick();
            chk($sformatf("hlt_hold%0d", i), {26'd0, halted, phase}, 32'h20);
        end
        reset = 1'b1;
        tick();
        chk("hlt_reset", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        run   = 1'b0;
        tick();
        chk("post_hlt_idle", {27'd0, phase}, 32'd0);

`ifdef SIMPLE_SINGLE_STEP_EN
        instruction = 16'hC000;
        step        = 1'b1;
        tick();
        ph[0] = phase;
        for (int i = 1; i < 5; i++) begin
            tick();
            ph[i] = phase;
        end
        chk_phases("step");
        tick();
        chk("step_idle", {27'd0, phase}, 32'd0);
        tick();
        tick();
        chk("step_held_idle", {27'd0, phase}, 32'd0);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        chk("step2_p1", {27'd0, phase}, 32'h01);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        chk("step_ignored_busy", {27'd0, phase}, 32'h04);
        tick();
        tick();
        tick();
        chk("step2_idle", {27'd0, phase}, 32'd0);
        step = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
